// File: rtl/scan_mux_if.sv
`default_nettype none
// ============================================================================
// scan_mux_if : channel data, control and registered result of scan_mux
// Rev 1.0
// ============================================================================
interface scan_mux_if #(
  parameter int W  = 1,
  parameter int N  = 4,
  parameter int SW = 2
) ();
  logic [N*W-1:0] din;
  logic [SW-1:0]  sel;
  logic           mode;
  logic           hold;
  logic [W-1:0]   d;
  logic [SW-1:0]  ch;
  logic           strobe;

  modport master (
    output din, sel, mode, hold,
    input  d, ch, strobe
  );

  modport slave (
    input  din, sel, mode, hold,
    output d, ch, strobe
  );
endinterface
`default_nettype wire

// File: rtl/scan_mux.sv
`default_nettype none
// ============================================================================
// scan_mux : registered N-channel W-bit mux, manual select or dwell-timed scan
// Rev 1.0
// ============================================================================
module scan_mux #(
  parameter int W     = 1,
  parameter int N     = 4,
  parameter int SW    = 2,
  parameter int DWELL = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  scan_mux_if.slave bus
);
  localparam int              CW         = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]   c_cnt_last = CW'(DWELL - 1);
  localparam logic [SW-1:0]   c_ch_last  = SW'(N - 1);

  logic [W-1:0]  r_d;
  logic [SW-1:0] r_ch;
  logic [CW-1:0] r_cnt;
  logic          r_strobe;

  logic [SW-1:0] w_ch_next;
  logic [CW-1:0] w_cnt_next;
  logic [W-1:0]  w_d_next;
  logic [W-1:0]  w_chan [N];

  genvar k;
  generate
    for (k = 0; k < N; k++) begin : g_slice
      assign w_chan[k] = bus.din[k*W +: W];
    end
  endgenerate

  // A channel left out of range by manual select wraps to 0 on the next scan step.
  always_comb begin
    w_ch_next  = r_ch;
    w_cnt_next = r_cnt;
    if (!bus.hold) begin
      if (!bus.mode) begin
        w_ch_next  = bus.sel;
        w_cnt_next = '0;
      end else if (r_cnt >= c_cnt_last) begin
        w_cnt_next = '0;
        w_ch_next  = (r_ch >= c_ch_last) ? '0 : r_ch + SW'(1);
      end else begin
        w_cnt_next = r_cnt + CW'(1);
      end
    end
  end

  // Indices with no matching channel select zero data.
  always_comb begin
    w_d_next = '0;
    for (int i = 0; i < N; i++) begin
      if (w_ch_next == SW'(i)) begin
        w_d_next = w_chan[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d      <= '0;
      r_ch     <= '0;
      r_cnt    <= '0;
      r_strobe <= 1'b0;
    end else if (bus.hold) begin
      r_strobe <= 1'b0;
    end else begin
      r_d      <= w_d_next;
      r_ch     <= w_ch_next;
      r_cnt    <= w_cnt_next;
      r_strobe <= (w_ch_next != r_ch);
    end
  end

  assign bus.d      = r_d;
  assign bus.ch     = r_ch;
  assign bus.strobe = r_strobe;
endmodule
`default_nettype wire

// File: tb/tb_scan_mux.sv
`default_nettype none
// ============================================================================
// tb_scan_mux : directed checks of scan_mux (4x1b dwell 4, and 3x8b dwell 1)
// Rev 1.0
// ============================================================================
module tb_scan_mux;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  scan_mux_if #(.W(1), .N(4), .SW(2)) bus_a ();
  scan_mux_if #(.W(8), .N(3), .SW(2)) bus_b ();

  scan_mux #(.W(1), .N(4), .SW(2), .DWELL(4)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  scan_mux #(.W(8), .N(3), .SW(2), .DWELL(1)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus_a.d !== 1'b0 || bus_a.ch !== 2'd0 || bus_a.strobe !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_a got d=%b ch=%0d st=%b want 0 0 0", bus_a.d, bus_a.ch, bus_a.strobe);
    end
    checks++;
    if (bus_b.d !== 8'h00 || bus_b.ch !== 2'd0 || bus_b.strobe !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_b got d=%h ch=%0d st=%b want 00 0 0", bus_b.d, bus_b.ch, bus_b.strobe);
    end
    tick();
    checks++;
    if (bus_a.d !== 1'b0 || bus_a.ch !== 2'd0 || bus_a.strobe !== 1'b0) begin
      errors++;
      $display("FAIL reset_held_a got d=%b ch=%0d st=%b want 0 0 0", bus_a.d, bus_a.ch, bus_a.strobe);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_manual();
    logic exp_d  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic exp_st [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    bus_a.din  = 4'b0001;
    bus_a.mode = 1'b0;
    for (int s = 0; s < 4; s++) begin
      bus_a.sel = 2'(s);
      tick();
      checks++;
      if (bus_a.ch !== 2'(s) || bus_a.d !== exp_d[s] || bus_a.strobe !== exp_st[s]) begin
        errors++;
        $display("FAIL manual_sel%0d got ch=%0d d=%b st=%b want ch=%0d d=%b st=%b",
                 s, bus_a.ch, bus_a.d, bus_a.strobe, s, exp_d[s], exp_st[s]);
      end
      tick();
      checks++;
      if (bus_a.ch !== 2'(s) || bus_a.strobe !== 1'b0) begin
        errors++;
        $display("FAIL manual_steady%0d got ch=%0d st=%b want ch=%0d st=0", s, bus_a.ch, bus_a.strobe, s);
      end
    end
  endtask

  task automatic test_scan();
    int   exp_ch [17] = '{0,0,0,0, 1,1,1,1, 2,2,2,2, 3,3,3,3, 0};
    logic exp_dd [17] = '{0,0,0,0, 1,1,1,1, 0,0,0,0, 1,1,1,1, 0};
    logic exp_st [17] = '{0,0,0,0, 1,0,0,0, 1,0,0,0, 1,0,0,0, 1};
    do_reset();
    bus_a.mode = 1'b1;
    bus_a.din  = 4'b1010;
    bus_a.sel  = 2'd2;
    for (int i = 0; i < 17; i++) begin
      if (i > 0) tick();
      checks++;
      if (bus_a.ch !== 2'(exp_ch[i]) || bus_a.d !== exp_dd[i] || bus_a.strobe !== exp_st[i]) begin
        errors++;
        $display("FAIL scan_step%0d got ch=%0d d=%b st=%b want ch=%0d d=%b st=%b",
                 i, bus_a.ch, bus_a.d, bus_a.strobe, exp_ch[i], exp_dd[i], exp_st[i]);
      end
    end
    bus_a.din = 4'b1011;
    tick();
    checks++;
    if (bus_a.ch !== 2'd0 || bus_a.d !== 1'b1) begin
      errors++;
      $display("FAIL scan_live_din got ch=%0d d=%b want ch=0 d=1", bus_a.ch, bus_a.d);
    end
  endtask

  task automatic test_hold();
    do_reset();
    bus_a.mode = 1'b1;
    bus_a.din  = 4'b1010;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (bus_a.ch !== 2'd1) begin
      errors++;
      $display("FAIL hold_setup got ch=%0d want 1", bus_a.ch);
    end
    bus_a.hold = 1'b1;
    bus_a.din  = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus_a.ch !== 2'd1 || bus_a.d !== 1'b1 || bus_a.strobe !== 1'b0) begin
        errors++;
        $display("FAIL hold_frozen%0d got ch=%0d d=%b st=%b want ch=1 d=1 st=0",
                 i, bus_a.ch, bus_a.d, bus_a.strobe);
      end
    end
    bus_a.hold = 1'b0;
    bus_a.din  = 4'b1010;
    tick();
    checks++;
    if (bus_a.ch !== 2'd1 || bus_a.strobe !== 1'b0) begin
      errors++;
      $display("FAIL hold_resume got ch=%0d st=%b want ch=1 st=0", bus_a.ch, bus_a.strobe);
    end
    tick();
    checks++;
    if (bus_a.ch !== 2'd2 || bus_a.d !== 1'b0 || bus_a.strobe !== 1'b1) begin
      errors++;
      $display("FAIL hold_next_ch got ch=%0d d=%b st=%b want ch=2 d=0 st=1", bus_a.ch, bus_a.d, bus_a.strobe);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus_a.mode = 1'b1;
    bus_a.din  = 4'b0100;
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (bus_a.ch !== 2'd2 || bus_a.d !== 1'b1) begin
      errors++;
      $display("FAIL arst_setup got ch=%0d d=%b want ch=2 d=1", bus_a.ch, bus_a.d);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (bus_a.ch !== 2'd0 || bus_a.d !== 1'b0 || bus_a.strobe !== 1'b0) begin
      errors++;
      $display("FAIL arst_immediate got ch=%0d d=%b st=%b want 0 0 0", bus_a.ch, bus_a.d, bus_a.strobe);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (bus_a.ch !== 2'd0 || bus_a.d !== 1'b0 || bus_a.strobe !== 1'b0) begin
        errors++;
        $display("FAIL arst_dwell%0d got ch=%0d d=%b st=%b want ch=0 d=0 st=0",
                 i, bus_a.ch, bus_a.d, bus_a.strobe);
      end
    end
    tick();
    checks++;
    if (bus_a.ch !== 2'd1 || bus_a.strobe !== 1'b1) begin
      errors++;
      $display("FAIL arst_advance got ch=%0d st=%b want ch=1 st=1", bus_a.ch, bus_a.strobe);
    end
  endtask

  task automatic test_mode_switch();
    do_reset();
    bus_a.mode = 1'b1;
    bus_a.din  = 4'b1010;
    for (int i = 0; i < 9; i++) tick();
    bus_a.mode = 1'b0;
    bus_a.sel  = 2'd0;
    tick();
    checks++;
    if (bus_a.ch !== 2'd0 || bus_a.d !== 1'b0 || bus_a.strobe !== 1'b1) begin
      errors++;
      $display("FAIL mode_to_manual got ch=%0d d=%b st=%b want ch=0 d=0 st=1", bus_a.ch, bus_a.d, bus_a.strobe);
    end
    bus_a.mode = 1'b1;
    bus_a.sel  = 2'd3;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (bus_a.ch !== 2'd0 || bus_a.strobe !== 1'b0) begin
        errors++;
        $display("FAIL mode_to_scan_dwell%0d got ch=%0d st=%b want ch=0 st=0", i, bus_a.ch, bus_a.strobe);
      end
    end
    tick();
    checks++;
    if (bus_a.ch !== 2'd1 || bus_a.d !== 1'b1 || bus_a.strobe !== 1'b1) begin
      errors++;
      $display("FAIL mode_to_scan_adv got ch=%0d d=%b st=%b want ch=1 d=1 st=1", bus_a.ch, bus_a.d, bus_a.strobe);
    end
  endtask

  task automatic test_param_sweep();
    logic [1:0] exp_ch [4] = '{2'd1, 2'd2, 2'd0, 2'd1};
    logic [7:0] exp_d  [4] = '{8'h5A, 8'hC3, 8'hFF, 8'h5A};
    do_reset();
    bus_b.mode = 1'b1;
    bus_b.din  = {8'hC3, 8'h5A, 8'hFF};
    checks++;
    if (bus_b.ch !== 2'd0 || bus_b.d !== 8'h00) begin
      errors++;
      $display("FAIL sweep_start got ch=%0d d=%h want ch=0 d=00", bus_b.ch, bus_b.d);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus_b.ch !== exp_ch[i] || bus_b.d !== exp_d[i] || bus_b.strobe !== 1'b1) begin
        errors++;
        $display("FAIL sweep_step%0d got ch=%0d d=%h st=%b want ch=%0d d=%h st=1",
                 i, bus_b.ch, bus_b.d, bus_b.strobe, exp_ch[i], exp_d[i]);
      end
    end
    bus_b.mode = 1'b0;
    bus_b.sel  = 2'd3;
    tick();
    checks++;
    if (bus_b.ch !== 2'd3 || bus_b.d !== 8'h00 || bus_b.strobe !== 1'b1) begin
      errors++;
      $display("FAIL sweep_oor got ch=%0d d=%h st=%b want ch=3 d=00 st=1", bus_b.ch, bus_b.d, bus_b.strobe);
    end
    tick();
    checks++;
    if (bus_b.ch !== 2'd3 || bus_b.d !== 8'h00 || bus_b.strobe !== 1'b0) begin
      errors++;
      $display("FAIL sweep_oor_steady got ch=%0d d=%h st=%b want ch=3 d=00 st=0", bus_b.ch, bus_b.d, bus_b.strobe);
    end
    bus_b.mode = 1'b1;
    tick();
    checks++;
    if (bus_b.ch !== 2'd0 || bus_b.d !== 8'hFF || bus_b.strobe !== 1'b1) begin
      errors++;
      $display("FAIL sweep_oor_wrap got ch=%0d d=%h st=%b want ch=0 d=ff st=1", bus_b.ch, bus_b.d, bus_b.strobe);
    end
    bus_b.mode = 1'b0;
    bus_b.sel  = 2'd2;
    tick();
    checks++;
    if (bus_b.ch !== 2'd2 || bus_b.d !== 8'hC3) begin
      errors++;
      $display("FAIL sweep_manual2 got ch=%0d d=%h want ch=2 d=c3", bus_b.ch, bus_b.d);
    end
  endtask

  initial begin
    bus_a.din  = '0;
    bus_a.sel  = '0;
    bus_a.mode = 1'b0;
    bus_a.hold = 1'b0;
    bus_b.din  = '0;
    bus_b.sel  = '0;
    bus_b.mode = 1'b0;
    bus_b.hold = 1'b0;
    test_reset();
    test_manual();
    test_scan();
    test_hold();
    test_async_reset();
    test_mode_switch();
    test_param_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/scan_mux.md
Name: scan_mux

Overview:
- Parametrised, registered N-channel, W-bit multiplexer; successor to the 4:1 one-bit combinational mux.
- Has two modes:
  - manual select, driven by a select bus;
  - auto-scan, where an internal dwell counter steps through the channels in order.
- Adds a hold/freeze control and a channel-change strobe.
- Used as the data-path selector in front of display and probe logic in later lab parts.

Parameters:
- W, 1, data width per channel in bits.
- N, 4, number of input channels (2..16; need not be a power of two).
- SW, 2, select/channel-index width; must satisfy 2**SW >= N.
- DWELL, 4, clock cycles spent on each channel in scan mode (>= 1).

Ports:
- clk, input, 1, system clock; all state changes on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- din, input, N*W, packed channel data; channel k occupies bits [k*W+W-1 : k*W].
- sel, input, SW, channel index used in manual mode.
- mode, input, 1, 0 = manual, 1 = auto-scan.
- hold, input, 1, 1 = freeze all state.
- d, output, W, registered selected data.
- ch, output, SW, registered index of the channel currently driving d.
- strobe, output, 1, one-cycle pulse when ch has just changed.

Behaviour:
- Reset: rst_n low forces d=0, ch=0, strobe=0 and dwell counter cnt=0 immediately, with no clock needed. Release is synchronous to the next rising edge.
  - Reset asserted mid-scan aborts the scan.
  - After release, scanning restarts from channel 0 with cnt=0.
- Next-channel rule, per rising edge (hold=0):
  - Manual (mode=0): ch_next = sel; cnt <= 0.
  - Scan (mode=1), cnt < DWELL-1: cnt <= cnt+1; ch_next = ch.
  - Scan (mode=1), cnt = DWELL-1: cnt <= 0; ch_next = ch+1, wrapping from N-1 to 0.
  - DWELL=1: ch advances every cycle.
- Registered outputs:
  - ch <= ch_next.
  - d <= din slice of ch_next, sampled at the same edge, so d and ch always describe the same channel.
  - Latency from sel or din to d is 1 cycle.
  - In scan mode d tracks live din of the current channel every cycle, not only at dwell boundaries.
- Out-of-range index:
  - Manual with sel >= N: ch <= sel, d <= 0.
  - Scan never produces an index >= N.
- strobe <= 1 when ch_next != ch, otherwise 0. It is high for exactly one cycle per change, in either mode.
- hold=1: d, ch and cnt keep their values; strobe <= 0. Hold has priority over mode and sel. On release, operation resumes with the retained cnt, so there is no dwell loss and no skipped channel.
- Mode switches:
  - Manual -> scan: first scan cycle starts with cnt=0 (guaranteed by manual mode clearing cnt) and dwells on the current ch.
  - Scan -> manual: sel takes effect at the next edge; cnt clears.
- Simultaneous events: rst_n beats hold, which beats the mode logic. A sel change while in scan mode is ignored.
- The design is synthesisable and free of latches. Width arithmetic on cnt uses clog2(DWELL) bits, minimum 1.

Test Plan (N=4, W=1, DWELL=4 unless stated):
- Manual walk: din=4'b0001, mode=0, sel=0,1,2,3, one per 100 ns phase -> d=1,0,0,0; ch follows sel one cycle later; strobe pulses once per sel change.
- Scan: mode=1, hold=0, din=4'b1010 after reset -> ch follows 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0; d = 0 on ch0/ch2 and 1 on ch1/ch3; strobe high on the first cycle of each new ch, including the 3->0 wrap.
- Hold mid-scan: assert hold for 5 cycles at cnt=2 on ch1 -> d, ch frozen, strobe=0. After release, ch1 lasts exactly 1 more cycle (cnt 2->3), then ch2.
- Asynchronous reset mid-scan: drop rst_n between edges while on ch2 -> d=0, ch=0, strobe=0 immediately. After release, scan restarts at ch0 with a full 4-cycle dwell.
- Parameter sweep: N=3, W=8, DWELL=1, din={8'hC3,8'h5A,8'hFF} -> ch cycles 0,1,2,0 every cycle; d=FF,5A,C3,FF. Manual sel=3 -> d=8'h00, ch=3.
- Mode switch: scan on ch2 at cnt=1, then mode=0 with sel=0 -> next edge ch=0, strobe=1. mode=1 again -> ch0 dwells a full 4 cycles.
